alu_sequencer: RTL

//  - Upstream control stage for the ALU datapath: accepts one command (opcode + two operands)
//    on a valid/ready interface, then runs the store_a / store_b / start / alu_done protocol.
//  - Captures result and overflow and presents them on a valid/ready response interface.
//  - Owns all timing of the datapath controls; the datapath never sees host traffic directly.

---
 rtl/alu_sequencer_pkg.sv | 24 ++
 rtl/alu_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared constants and state encoding for the ALU command sequencer.
// Operand width matches the datapath; opcodes are passed through unchanged.
package alu_sequencer_pkg;

   localparam int DATA_WIDTH = 8;

   localparam logic [1:0] ADD  = 2'd0;
   localparam logic [1:0] SUB  = 2'd1;
   localparam logic [1:0] PAR  = 2'd2;
   localparam logic [1:0] COMP = 2'd3;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      START  = 3'd3,
      WAIT   = 3'd4,
      RESP   = 3'd5
   } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Command/response front end that drives the ALU datapath load/start/done handshake.
// Optional WAIT-state watchdog is compiled in with ALU_TIMEOUT_EN.
module alu_sequencer #(
   parameter int DATA_WIDTH     = alu_sequencer_pkg::DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_opcode,
   input  logic [DATA_WIDTH-1:0]  cmd_a,
   input  logic [DATA_WIDTH-1:0]  cmd_b,
   output logic [DATA_WIDTH-1:0]  alu_data,
   output logic [1:0]             opcode_value,
   output logic                   store_a,
   output logic                   store_b,
   output logic                   start,
   input  logic                   alu_done,
   input  logic [DATA_WIDTH-1:0]  result,
   input  logic                   overflow_def,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_WIDTH-1:0]  rsp_result,
   output logic                   rsp_overflow,
   output logic                   rsp_timeout,
   output logic [COUNT_WIDTH-1:0] op_count
);
   import alu_sequencer_pkg::*;

   state_t                 state_reg, state_next;
   logic                   armed_reg;
   logic [1:0]             op_reg;
   logic [DATA_WIDTH-1:0]  a_reg, b_reg, res_reg;
   logic                   ovf_reg;
   logic [COUNT_WIDTH-1:0] count_reg;
   logic                   accept, capture, rsp_fire;
`ifdef ALU_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0]      wait_cnt_reg;
   logic                   tmo_reg, timed_out;
`endif

   always_comb begin
      state_next = state_reg;
      cmd_ready  = OFF;
      store_a    = OFF;
      store_b    = OFF;
      start      = OFF;
      alu_data   = '0;
      rsp_valid  = OFF;
      accept     = OFF;
      capture    = OFF;
      rsp_fire   = OFF;
`ifdef ALU_TIMEOUT_EN
      timed_out  = OFF;
`endif
      case (state_reg)
         IDLE: begin
            // armed_reg keeps cmd_ready low for the first cycle out of reset
            cmd_ready = armed_reg;
            if (cmd_valid && armed_reg) begin
               accept     = ON;
               state_next = LOAD_A;
            end
         end
         LOAD_A: begin
            alu_data   = a_reg;
            store_a    = ON;
            state_next = LOAD_B;
         end
         LOAD_B: begin
            alu_data   = b_reg;
            store_b    = ON;
            state_next = START;
         end
         START: begin
            start      = ON;
            state_next = WAIT;
         end
         WAIT: begin
            start = ON;
            if (alu_done) begin
               capture    = ON;
               state_next = RESP;
            end
`ifdef ALU_TIMEOUT_EN
            else if (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
               timed_out  = ON;
               state_next = RESP;
            end
`endif
         end
         RESP: begin
            rsp_valid = ON;
            if (rsp_ready) begin
               rsp_fire   = ON;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         armed_reg <= OFF;
      end else begin
         state_reg <= state_next;
         armed_reg <= ON;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_reg    <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         ovf_reg   <= OFF;
         count_reg <= '0;
`ifdef ALU_TIMEOUT_EN
         tmo_reg      <= OFF;
         wait_cnt_reg <= '0;
`endif
      end else begin
         if (accept) begin
            op_reg <= cmd_opcode;
            a_reg  <= cmd_a;
            b_reg  <= cmd_b;
         end
         if (capture) begin
            res_reg <= result;
            ovf_reg <= overflow_def;
         end
         if (rsp_fire)
            count_reg <= count_reg + 1'b1;
`ifdef ALU_TIMEOUT_EN
         if (capture)
            tmo_reg <= OFF;
         if (timed_out) begin
            res_reg <= '0;
            ovf_reg <= OFF;
            tmo_reg <= ON;
         end
         wait_cnt_reg <= (state_reg == WAIT) ? wait_cnt_reg + 1'b1 : '0;
`endif
      end
   end

   assign opcode_value = (state_reg == IDLE) ? 2'b00 : op_reg;
   assign rsp_result   = (state_reg == RESP) ? res_reg : '0;
   assign rsp_overflow = (state_reg == RESP) & ovf_reg;
`ifdef ALU_TIMEOUT_EN
   assign rsp_timeout  = (state_reg == RESP) & tmo_reg;
`else
   assign rsp_timeout  = OFF;
`endif
   assign op_count     = count_reg;

endmodule
